// File: rtl/alu_seq_accum_pkg.sv
// Shared opcode and FSM encodings for the sequential accumulator ALU.
// Every block that decodes opcodes or inspects the FSM imports these definitions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_LOG = 3'd2,
    OP_OR  = 3'd3,
    OP_POP = 3'd4,
    OP_CAT = 3'd5,
    OP_REG = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_accum_if.sv
// Request/result bundle between the board input logic and the ALU.
// Handshake: start is sampled only while busy=0. A non-multiply request completes on the
// same edge, and done pulses high for the following cycle. OP_MUL raises busy for WIDTH
// cycles, then pulses done. done and busy are never high together, and start is ignored
// while busy.
interface alu_seq_accum_if #(
  parameter int WIDTH = 4
);
  import alu_pkg::*;

  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               use_acc;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;
  state_t             dbg_state;

  modport master (
    output start, op, a, b, cin, use_acc,
    input  result, busy, done, dbg_state
  );

  modport slave (
    input  start, op, a, b, cin, use_acc,
    output result, busy, done, dbg_state
  );

endinterface

// File: rtl/alu_seq_accum_ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full adders.
// Used for OP_ADD and for each accumulate step of the shift-add multiplier.
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/alu_seq_accum.sv
// Clocked ALU with an accumulator feedback path, a start/busy/done handshake and a
// multi-cycle shift-add multiplier. WIDTH must be at least 2.
module alu_seq_accum
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int POP_A = 1,
  parameter int POP_B = 2
) (
  input  logic             clock,
  input  logic             resetn,
  alu_seq_accum_if.slave   bus
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W2-1:0]      r_result;
  logic [W2-1:0]      w_result_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_load_mul;
  logic               w_step_mul;
  logic [WIDTH-1:0]   r_mcand;
  logic [W2-1:0]      r_prod;
  logic [W2-1:0]      w_prod_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_a_eff;
  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_cout;
  logic [WIDTH-1:0]   w_step_b;
  logic [WIDTH-1:0]   w_step_sum;
  logic               w_step_cout;
  logic [WIDTH:0]     w_sub;
  logic [W2-1:0]      w_op_result;

  function automatic int popcnt(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  assign w_a_eff = bus.use_acc ? r_result[WIDTH-1:0] : bus.a;

  ripple_adder #(.WIDTH(WIDTH)) u_add (
    .i_a    (w_a_eff),
    .i_b    (bus.b),
    .i_cin  (bus.cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Multiplier holds {partial_hi, multiplier_lo}; each step adds the multiplicand to the
  // high half when the current multiplier bit is set, then shifts the whole thing right.
  assign w_step_b = r_prod[0] ? r_mcand : '0;

  ripple_adder #(.WIDTH(WIDTH)) u_mul_step (
    .i_a    (r_prod[W2-1:WIDTH]),
    .i_b    (w_step_b),
    .i_cin  (1'b0),
    .o_sum  (w_step_sum),
    .o_cout (w_step_cout)
  );

  assign w_prod_nxt = {w_step_cout, w_step_sum, r_prod[WIDTH-1:1]};
  assign w_sub      = {1'b0, w_a_eff} - {1'b0, bus.b};

  always_comb begin
    w_op_result = '0;
    case (op_t'(bus.op))
      OP_ADD: w_op_result = W2'({w_add_cout, w_add_sum});
      OP_SUB: w_op_result = W2'(w_sub);
      OP_LOG: w_op_result = {~(w_a_eff ^ bus.b), ~(w_a_eff & bus.b)};
      OP_OR:  w_op_result = ((|w_a_eff) || (|bus.b)) ? W2'({WIDTH{1'b1}}) : '0;
      OP_POP: w_op_result = ((popcnt(w_a_eff) == POP_A) && (popcnt(bus.b) == POP_B))
                            ? {{WIDTH{1'b1}}, {WIDTH{1'b0}}} : '0;
      OP_CAT: w_op_result = {w_a_eff, ~bus.b};
      OP_REG: w_op_result = bus.cin ? r_result : '0;
      default: w_op_result = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    w_load_mul   = 1'b0;
    w_step_mul   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_t'(bus.op) == OP_MUL) begin
            w_load_mul  = 1'b1;
            w_state_nxt = ST_MUL;
          end else begin
            w_result_nxt = w_op_result;
            w_done_nxt   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_step_mul = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_result_nxt = w_prod_nxt;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_load_mul) begin
      r_mcand <= w_a_eff;
      r_prod  <= {{WIDTH{1'b0}}, bus.b};
      r_cnt   <= '0;
    end else if (w_step_mul) begin
      r_prod  <= w_prod_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign bus.result    = r_result;
  assign bus.busy      = (r_state == ST_MUL);
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule
